ddr3_init_sequencer: RTL and testbench

- Power-up/initialization sequencer that sits directly upstream of the DDR3 PHY layer.
- Generates the JEDEC DDR3 init command stream: reset hold, CKE-low hold, tXPR wait, MRS to MR2/MR3/MR1/MR0, ZQCL, tZQinit wait.
- Drives the PHY's command_t input and mode-register-select input.
- Raises o_init_done when init completes, so the downstream mux can hand the PHY over to the command scheduler.

---
 rtl/ddr3_init_sequencer.sv | 120 ++++++++++++
 tb/tb_ddr3_init_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up initialization sequencer: reset hold, CKE-low hold, tXPR,
// MRS to MR2/MR3/MR1/MR0, ZQCL and tZQinit, then hands the PHY to the scheduler.
package ddr3_init_pkg;
  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_RESET    = 3'd1,
    CMD_POWER_UP = 3'd2,
    CMD_MRS      = 3'd3,
    CMD_ZQCAL    = 3'd4
  } command_t;
endpackage

module ddr3_init_sequencer
  import ddr3_init_pkg::*;
#(
  parameter int CNT_W     = 20,
  parameter int T_RESET   = 200,
  parameter int T_CKE_LOW = 500,
  parameter int T_XPR     = 120,
  parameter int T_MRD     = 4,
  parameter int T_MOD     = 12,
  parameter int T_ZQINIT  = 512
) (
  input  logic           clk1,
  input  logic           rst_n,
  input  logic           i_reinit,
  output command_t       o_command,
  output logic [1:0]     o_mode_register_num,
  output logic           o_init_done,
  output logic [3:0]     o_state
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_CKE_LOW = 4'd1,
    S_XPR     = 4'd2,
    S_MR2     = 4'd3,
    S_MR3     = 4'd4,
    S_MR1     = 4'd5,
    S_MR0     = 4'd6,
    S_ZQ      = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  assign o_state = state;

  function automatic state_t next_state(input state_t s);
    case (s)
      S_RESET:   next_state = S_CKE_LOW;
      S_CKE_LOW: next_state = S_XPR;
      S_XPR:     next_state = S_MR2;
      S_MR2:     next_state = S_MR3;
      S_MR3:     next_state = S_MR1;
      S_MR1:     next_state = S_MR0;
      S_MR0:     next_state = S_ZQ;
      default:   next_state = S_DONE;
    endcase
  endfunction

  // Counter preload is the state duration minus one, so exit happens on cnt==0.
  function automatic logic [CNT_W-1:0] load_val(input state_t s);
    case (s)
      S_RESET:               load_val = CNT_W'(T_RESET - 1);
      S_CKE_LOW:             load_val = CNT_W'(T_CKE_LOW - 1);
      S_XPR:                 load_val = CNT_W'(T_XPR - 1);
      S_MR2, S_MR3, S_MR1:   load_val = CNT_W'(T_MRD - 1);
      S_MR0:                 load_val = CNT_W'(T_MOD - 1);
      S_ZQ:                  load_val = CNT_W'(T_ZQINIT - 1);
      default:               load_val = '0;
    endcase
  endfunction

  function automatic command_t entry_cmd(input state_t s);
    case (s)
      S_RESET:                    entry_cmd = CMD_RESET;
      S_CKE_LOW:                  entry_cmd = CMD_POWER_UP;
      S_MR2, S_MR3, S_MR1, S_MR0: entry_cmd = CMD_MRS;
      S_ZQ:                       entry_cmd = CMD_ZQCAL;
      default:                    entry_cmd = CMD_NOP;
    endcase
  endfunction

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_RESET;
      cnt                 <= CNT_W'(T_RESET - 1);
      o_command           <= CMD_RESET;
      o_mode_register_num <= 2'd0;
      o_init_done         <= 1'b0;
    end else if (state == S_DONE) begin
      if (i_reinit) begin
        state       <= S_RESET;
        cnt         <= load_val(S_RESET);
        o_command   <= CMD_RESET;
        o_init_done <= 1'b0;
      end
    end else if (cnt == '0) begin
      state       <= next_state(state);
      cnt         <= load_val(next_state(state));
      o_command   <= entry_cmd(next_state(state));
      o_init_done <= (next_state(state) == S_DONE);
      case (next_state(state))
        S_MR2:   o_mode_register_num <= 2'd2;
        S_MR3:   o_mode_register_num <= 2'd3;
        S_MR1:   o_mode_register_num <= 2'd1;
        S_MR0:   o_mode_register_num <= 2'd0;
        default: o_mode_register_num <= o_mode_register_num;
      endcase
    end else begin
      cnt <= cnt - 1'b1;
      // MRS/ZQCL are single-cycle strobes; the rest of those states is NOP padding.
      if (state inside {S_MR2, S_MR3, S_MR1, S_MR0, S_ZQ})
        o_command <= CMD_NOP;
    end
  end

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Bench for ddr3_init_sequencer: segment tables expanded per cycle into a
// scoreboard queue, compared against three differently parameterised instances.
module tb_ddr3_init_sequencer;
  import ddr3_init_pkg::*;

  localparam int DEF_DONE = 200 + 500 + 120 + 3*4 + 12 + 512;

  typedef struct {
    command_t   cmd;
    logic [1:0] mr;
    logic       done;
    logic [3:0] st;
  } out_t;

  typedef struct {
    int   lo;
    int   hi;
    out_t o;
  } seg_t;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic rstn_a = 1'b0, rstn_b = 1'b0, rstn_c = 1'b0;
  logic reinit_a = 1'b0, reinit_b = 1'b0, reinit_c = 1'b0;
  command_t   cmd_a, cmd_b, cmd_c;
  logic [1:0] mr_a, mr_b, mr_c;
  logic       done_a, done_b, done_c;
  logic [3:0] st_a, st_b, st_c;

  int   total = 0;
  int   bad   = 0;
  seg_t segs[$];
  out_t exp_q[$];

  ddr3_init_sequencer #(.CNT_W(20), .T_RESET(4), .T_CKE_LOW(5), .T_XPR(3),
                        .T_MRD(4), .T_MOD(6), .T_ZQINIT(8)) dut_a (
    .clk1(clk1), .rst_n(rstn_a), .i_reinit(reinit_a), .o_command(cmd_a),
    .o_mode_register_num(mr_a), .o_init_done(done_a), .o_state(st_a));

  ddr3_init_sequencer #(.CNT_W(20), .T_RESET(1), .T_CKE_LOW(1), .T_XPR(1),
                        .T_MRD(1), .T_MOD(1), .T_ZQINIT(1)) dut_b (
    .clk1(clk1), .rst_n(rstn_b), .i_reinit(reinit_b), .o_command(cmd_b),
    .o_mode_register_num(mr_b), .o_init_done(done_b), .o_state(st_b));

  ddr3_init_sequencer dut_c (
    .clk1(clk1), .rst_n(rstn_c), .i_reinit(reinit_c), .o_command(cmd_c),
    .o_mode_register_num(mr_c), .o_init_done(done_c), .o_state(st_c));

  task automatic get_out(input int sel, output out_t a);
    case (sel)
      0:       begin a.cmd = cmd_a; a.mr = mr_a; a.done = done_a; a.st = st_a; end
      1:       begin a.cmd = cmd_b; a.mr = mr_b; a.done = done_b; a.st = st_b; end
      default: begin a.cmd = cmd_c; a.mr = mr_c; a.done = done_c; a.st = st_c; end
    endcase
  endtask

  task automatic check(input string name, input int k, input out_t a, input out_t e);
    total++;
    if (a.cmd !== e.cmd || a.mr !== e.mr || a.done !== e.done || a.st !== e.st) begin
      bad++;
      $display("FAIL %s cycle=%0d got cmd=%0d mr=%0d done=%0b st=%0d want cmd=%0d mr=%0d done=%0b st=%0d",
               name, k, a.cmd, a.mr, a.done, a.st, e.cmd, e.mr, e.done, e.st);
    end
  endtask

  task automatic add_seg(input int lo, input int hi, input command_t c,
                         input logic [1:0] mr, input logic d, input logic [3:0] st);
    seg_t s;
    if (hi >= lo) begin
      s.lo = lo; s.hi = hi;
      s.o.cmd = c; s.o.mr = mr; s.o.done = d; s.o.st = st;
      segs.push_back(s);
    end
  endtask

  // Expected command stream laid out from the state durations, starting at cycle off.
  task automatic add_seq(input int off, input int tr, input int tc, input int tx,
                         input int tm, input int tmod, input int tz, input int done_hi);
    int c;
    int mrs[4];
    int dur;
    mrs = '{2, 3, 1, 0};
    c = off;
    add_seg(c, c + tr - 1, CMD_RESET, 2'd0, 1'b0, 4'd0);    c += tr;
    add_seg(c, c + tc - 1, CMD_POWER_UP, 2'd0, 1'b0, 4'd1); c += tc;
    add_seg(c, c + tx - 1, CMD_NOP, 2'd0, 1'b0, 4'd2);      c += tx;
    for (int i = 0; i < 4; i++) begin
      dur = (i == 3) ? tmod : tm;
      add_seg(c, c, CMD_MRS, 2'(mrs[i]), 1'b0, 4'(3 + i));
      add_seg(c + 1, c + dur - 1, CMD_NOP, 2'(mrs[i]), 1'b0, 4'(3 + i));
      c += dur;
    end
    add_seg(c, c, CMD_ZQCAL, 2'd0, 1'b0, 4'd7);
    add_seg(c + 1, c + tz - 1, CMD_NOP, 2'd0, 1'b0, 4'd7);
    c += tz;
    add_seg(c, done_hi, CMD_NOP, 2'd0, 1'b1, 4'd8);
  endtask

  // Called at a negedge; iteration k samples cycle k and drives i_reinit for posedge k.
  task automatic play(input int sel, input int ncyc, input int rlo, input int rhi,
                      input string name);
    out_t e, a;
    bit found;
    for (int k = 0; k < ncyc; k++) begin
      if (sel == 0) reinit_a = (k >= rlo && k <= rhi);
      found = 1'b0;
      e = '{CMD_NOP, 2'd0, 1'b0, 4'd0};
      foreach (segs[i])
        if (k >= segs[i].lo && k <= segs[i].hi) begin
          e = segs[i].o;
          found = 1'b1;
        end
      if (!found) begin
        total++; bad++;
        $display("FAIL %s cycle=%0d no expectation in table", name, k);
      end else begin
        exp_q.push_back(e);
        get_out(sel, a);
        check(name, k, a, exp_q.pop_front());
      end
      @(posedge clk1);
      @(negedge clk1);
    end
    reinit_a = 1'b0;
    segs.delete();
  endtask

  task automatic restart_a();
    rstn_a = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    rstn_a = 1'b1;
  endtask

  initial begin
    out_t a, rv;
    rv = '{CMD_RESET, 2'd0, 1'b0, 4'd0};
    @(negedge clk1);
    @(negedge clk1);
    get_out(0, a);
    check("reset_hold", -1, a, rv);
    rstn_a = 1'b1;

    // Nominal sequence with short timings.
    add_seq(0, 4, 5, 3, 4, 6, 8, 45);
    play(0, 46, -1, -1, "seq_nominal");

    // Async reset inside S_MR3, then full replay.
    restart_a();
    add_seq(0, 4, 5, 3, 4, 6, 8, 45);
    play(0, 17, -1, -1, "seq_pre_reset");
    rstn_a = 1'b0;
    #1;
    get_out(0, a);
    check("async_reset", 17, a, rv);
    @(negedge clk1);
    @(negedge clk1);
    get_out(0, a);
    check("reset_held", 19, a, rv);
    rstn_a = 1'b1;
    add_seq(0, 4, 5, 3, 4, 6, 8, 45);
    play(0, 46, -1, -1, "seq_after_reset");

    // Single-cycle reinit pulse in S_DONE.
    restart_a();
    add_seq(0, 4, 5, 3, 4, 6, 8, 40);
    add_seq(41, 4, 5, 3, 4, 6, 8, 85);
    play(0, 86, 40, 40, "reinit_pulse");

    // Reinit held during the sequence is ignored.
    restart_a();
    add_seq(0, 4, 5, 3, 4, 6, 8, 45);
    play(0, 46, 0, 20, "reinit_ignored");

    // Reinit still high when S_DONE is reached restarts immediately.
    restart_a();
    add_seq(0, 4, 5, 3, 4, 6, 8, 38);
    add_seq(39, 4, 5, 3, 4, 6, 8, 51);
    play(0, 52, 0, 38, "reinit_at_done");

    // All durations one cycle.
    rstn_b = 1'b1;
    add_seq(0, 1, 1, 1, 1, 1, 1, 12);
    play(1, 13, -1, -1, "all_ones");

    // Default timings.
    rstn_c = 1'b1;
    add_seq(0, 200, 500, 120, 4, 12, 512, DEF_DONE + 4);
    play(2, DEF_DONE + 5, -1, -1, "defaults");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
